// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator for a raster pixel stream, feeding rank_order.
// Define WINDOW_ZERO_PAD_EN to emit a zero-padded window for every pixel.
module window_3x3_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int X_W    = 10,
  parameter int Y_W    = 10
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  input  logic              iSof,
  input  logic [DATA_W-1:0] iPixel,
  output logic              oValid,
  output logic [DATA_W-1:0] oNum1,
  output logic [DATA_W-1:0] oNum2,
  output logic [DATA_W-1:0] oNum3,
  output logic [DATA_W-1:0] oNum4,
  output logic [DATA_W-1:0] oNum5,
  output logic [DATA_W-1:0] oNum6,
  output logic [DATA_W-1:0] oNum7,
  output logic [DATA_W-1:0] oNum8,
  output logic [DATA_W-1:0] oNum9,
  output logic [X_W-1:0]    oX,
  output logic [Y_W-1:0]    oY,
  output logic              oEof
);

  localparam logic [X_W-1:0] LAST_X = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] LAST_Y = Y_W'(IMG_H - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t stateQ;
  state_t stateNext;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [X_W-1:0] curX;
  logic [Y_W-1:0] curY;
  logic           accept;
  logic           lastPix;
  logic           emit;

  logic [DATA_W-1:0] line1 [IMG_W];
  logic [DATA_W-1:0] line2 [IMG_W];
  logic [DATA_W-1:0] l1Rd;
  logic [DATA_W-1:0] l2Rd;

  // Index 0 = top row (y-2), 2 = bottom row (y)
  logic [2:0][DATA_W-1:0] col0;
  logic [2:0][DATA_W-1:0] col1;
  logic [2:0][DATA_W-1:0] colNew;
  logic [2:0][2:0][DATA_W-1:0] win;

  always_comb begin
    accept  = iValid && (iSof || (stateQ == RUN));
    curX    = iSof ? '0 : x;
    curY    = iSof ? '0 : y;
    lastPix = (curX == LAST_X) && (curY == LAST_Y);
  end

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE: if (iValid && iSof) stateNext = RUN;
      RUN:  if (accept && lastPix) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateQ <= IDLE;
      x      <= '0;
      y      <= '0;
    end else begin
      stateQ <= stateNext;
      if (accept) begin
        if (curX == LAST_X) begin
          x <= '0;
          y <= (curY == LAST_Y) ? '0 : curY + Y_W'(1);
        end else begin
          x <= curX + X_W'(1);
          y <= curY;
        end
      end
    end
  end

  assign l1Rd = line1[curX];
  assign l2Rd = line2[curX];

  always_ff @(posedge iClk) begin
    if (accept) begin
      line2[curX] <= l1Rd;
      line1[curX] <= iPixel;
    end
  end

  assign colNew = {iPixel, l1Rd, l2Rd};

  always_ff @(posedge iClk) begin
    if (iRst) begin
      col0 <= '0;
      col1 <= '0;
    end else if (accept) begin
      col0 <= col1;
      col1 <= colNew;
    end
  end

  always_comb begin
    win = '0;
    for (int r = 0; r < 3; r++) begin
      win[r][0] = col0[r];
      win[r][1] = col1[r];
      win[r][2] = colNew[r];
    end
`ifdef WINDOW_ZERO_PAD_EN
    // Rows/columns before the frame origin hold stale data
    if (curY < Y_W'(2)) win[0] = '0;
    if (curY < Y_W'(1)) win[1] = '0;
    for (int r = 0; r < 3; r++) begin
      if (curX < X_W'(2)) win[r][0] = '0;
      if (curX < X_W'(1)) win[r][1] = '0;
    end
`endif
  end

`ifdef WINDOW_ZERO_PAD_EN
  assign emit = accept;
`else
  assign emit = accept && (curX >= X_W'(2)) && (curY >= Y_W'(2));
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oValid <= 1'b0;
      oEof   <= 1'b0;
      oNum1  <= '0;
      oNum2  <= '0;
      oNum3  <= '0;
      oNum4  <= '0;
      oNum5  <= '0;
      oNum6  <= '0;
      oNum7  <= '0;
      oNum8  <= '0;
      oNum9  <= '0;
      oX     <= '0;
      oY     <= '0;
    end else begin
      oValid <= emit;
      oEof   <= emit && lastPix;
      if (emit) begin
        oNum1 <= win[0][0];
        oNum2 <= win[0][1];
        oNum3 <= win[0][2];
        oNum4 <= win[1][0];
        oNum5 <= win[1][1];
        oNum6 <= win[1][2];
        oNum7 <= win[2][0];
        oNum8 <= win[2][1];
        oNum9 <= win[2][2];
        oX    <= curX;
        oY    <= curY;
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomised bench for window_3x3_gen against a frame-image reference model.
// Follows WINDOW_ZERO_PAD_EN the same way the design does.
module tb_window_3x3_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int XW = 2;
  localparam int YW = 2;
`ifdef WINDOW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int NWIN = PAD ? W * H : (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic sof = 1'b0;
  logic [DW-1:0] pix = '0;
  logic oValid, oEof;
  logic [DW-1:0] n1, n2, n3, n4, n5, n6, n7, n8, n9;
  logic [XW-1:0] oX;
  logic [YW-1:0] oY;
  logic [71:0] dutTaps;

  always #5 clk = ~clk;

  window_3x3_gen #(
    .DATA_W(DW), .IMG_W(W), .IMG_H(H), .X_W(XW), .Y_W(YW)
  ) dut (
    .iClk(clk), .iRst(rst), .iValid(vld), .iSof(sof), .iPixel(pix),
    .oValid(oValid),
    .oNum1(n1), .oNum2(n2), .oNum3(n3),
    .oNum4(n4), .oNum5(n5), .oNum6(n6),
    .oNum7(n7), .oNum8(n8), .oNum9(n9),
    .oX(oX), .oY(oY), .oEof(oEof)
  );

  assign dutTaps = {n1, n2, n3, n4, n5, n6, n7, n8, n9};

  // Reference model: the image of the current frame plus a raster position
  int img [H][W];
  bit mRun = 1'b0;
  int mx = 0, my = 0, px, py;
  bit last;
  logic mValid = 1'b0, mEof = 1'b0;
  logic [71:0] mTaps = '0;
  int mX = 0, mY = 0;

  function automatic logic [71:0] winAt(int cx, int cy);
    logic [71:0] w;
    int rr, cc, v;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      rr = cy - 2 + k / 3;
      cc = cx - 2 + k % 3;
      v = (rr < 0 || cc < 0) ? 0 : img[rr][cc];
      w[71 - 8 * k -: 8] = v[7:0];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mRun = 1'b0; mx = 0; my = 0;
      mValid = 1'b0; mEof = 1'b0; mTaps = '0; mX = 0; mY = 0;
    end else begin
      mValid = 1'b0;
      mEof = 1'b0;
      if (vld && (sof || mRun)) begin
        if (sof) begin
          px = 0; py = 0;
          foreach (img[r, c]) img[r][c] = 0;
        end else begin
          px = mx; py = my;
        end
        img[py][px] = int'(pix);
        last = (px == W - 1) && (py == H - 1);
        if (PAD || (px >= 2 && py >= 2)) begin
          mValid = 1'b1;
          mEof = last;
          mX = px;
          mY = py;
          mTaps = winAt(px, py);
        end
        mx = (px + 1) % W;
        my = (px == W - 1) ? (py + 1) % H : py;
        mRun = !last;
      end
    end
  end

  typedef struct {
    logic [71:0] taps;
    int x;
    int y;
    bit eof;
  } win_t;

  win_t log[$];
  int nChecks = 0, nFail = 0, eofCnt = 0;

  task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle, then compare DUT outputs with the model at the negedge
  task automatic cyc(bit v, bit s, logic [DW-1:0] p, bit r);
    vld = v; sof = s; pix = p; rst = r;
    @(negedge clk);
    chk("oValid", oValid, mValid);
    chk("oEof", oEof, mEof);
    chk("taps", dutTaps, mTaps);
    chk("oX", oX, mX);
    chk("oY", oY, mY);
    if (oValid) begin
      log.push_back('{dutTaps, int'(oX), int'(oY), oEof});
      if (oEof) eofCnt++;
    end
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic frame(int base, int gapMax, bit rnd, int stopAt);
    for (int i = 0; i < W * H; i++) begin
      if (i == stopAt) return;
      idle($urandom_range(0, gapMax));
      cyc(1'b1, i == 0,
          rnd ? 8'($urandom) : 8'(base + 10 * (i / W) + (i % W) + 1), 1'b0);
    end
  endtask

  task automatic chkFrame(string nm, int l0, int e0);
    chk({nm, " windows"}, log.size() - l0, NWIN);
    chk({nm, " eofs"}, eofCnt - e0, 1);
  endtask

  int l0, e0, bad, abortAt;
  logic [7:0] b;

  initial begin
    cyc(1'b1, 1'b1, 8'd9, 1'b1);
    cyc(1'b1, 1'b1, 8'd9, 1'b1);
    chk("reset oValid", oValid, 0);
    chk("reset taps", dutTaps, 0);
    chk("reset xy eof", {oX, oY, oEof}, 0);

    l0 = log.size();
    repeat (3) cyc(1'b1, 1'b0, 8'd55, 1'b0);
    idle(2);
    chk("idle drop", log.size() - l0, 0);

    l0 = log.size(); e0 = eofCnt;
    frame(0, 0, 1'b0, -1);
    idle(2);
    chkFrame("contig", l0, e0);
`ifdef WINDOW_ZERO_PAD_EN
    chk("pad w00 taps", log[l0].taps, {64'd0, 8'd1});
    chk("pad w00 xy", 10 * log[l0].x + log[l0].y, 0);
    chk("pad w11 taps", log[l0 + 5].taps,
        {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd11, 8'd12});
    chk("pad w11 xy", 10 * log[l0 + 5].x + log[l0 + 5].y, 11);
    chk("pad last eof", log[l0 + 11].eof, 1);
`else
    chk("w0 taps", log[l0].taps,
        {8'd1, 8'd2, 8'd3, 8'd11, 8'd12, 8'd13, 8'd21, 8'd22, 8'd23});
    chk("w0 xy", 10 * log[l0].x + log[l0].y, 22);
    chk("w0 eof", log[l0].eof, 0);
    chk("w1 taps", log[l0 + 1].taps,
        {8'd2, 8'd3, 8'd4, 8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24});
    chk("w1 eof", log[l0 + 1].eof, 1);
`endif

    l0 = log.size(); e0 = eofCnt;
    frame(0, 3, 1'b0, -1);
    idle(3);
    chkFrame("gaps", l0, e0);
`ifdef WINDOW_ZERO_PAD_EN
    chk("gaps w11 taps", log[l0 + 5].taps,
        {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd11, 8'd12});
`else
    chk("gaps w0 taps", log[l0].taps,
        {8'd1, 8'd2, 8'd3, 8'd11, 8'd12, 8'd13, 8'd21, 8'd22, 8'd23});
`endif

    l0 = log.size(); e0 = eofCnt;
    frame(0, 0, 1'b0, 5);
    frame(100, 0, 1'b0, -1);
    idle(2);
    chkFrame("restart", l0, e0);
    bad = 0;
    for (int i = l0; i < log.size(); i++)
      for (int k = 0; k < 9; k++) begin
        b = log[i].taps[8 * k +: 8];
        if (!(PAD && b == 8'd0) && b < 8'd101) bad++;
      end
    chk("restart stale", bad, 0);

    frame(0, 1, 1'b0, 6);
    cyc(1'b1, 1'b0, 8'd13, 1'b1);
    chk("midrst oValid", oValid, 0);
    chk("midrst taps", dutTaps, 0);
    l0 = log.size();
    repeat (4) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    idle(2);
    chk("midrst drop", log.size() - l0, 0);
    l0 = log.size(); e0 = eofCnt;
    frame(0, 2, 1'b0, -1);
    idle(2);
    chkFrame("after rst", l0, e0);

    repeat (6) begin
      l0 = log.size(); e0 = eofCnt;
      abortAt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W * H - 1)) : -1;
      if (abortAt >= 0) frame(0, 3, 1'b1, abortAt);
      frame(0, 3, 1'b1, -1);
      idle(3);
      if (abortAt < 0) chkFrame("rand", l0, e0);
      else chk("rand eofs", eofCnt - e0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Builds 3x3 pixel neighbourhoods from a raster-scan pixel stream and presents them as nine parallel taps, matching the `iNum1`..`iNum9` inputs of `rank_order`. It sits upstream of the sorter in the median-filter datapath. It holds two line buffers and a 3x3 tap register array, and tracks the frame position. It emits one window per accepted pixel, or per interior pixel depending on configuration.

## Interface
- `DATA_W`, 8, pixel width
- `IMG_W`, 640, pixels per line (>= 3)
- `IMG_H`, 480, lines per frame (>= 3)
- `X_W`, 10, column counter width (2^X_W >= IMG_W)
- `Y_W`, 10, row counter width (2^Y_W >= IMG_H)

Ports:
- `iClk`  in  1  clock; single clock domain
- `iRst`  in  1  reset; synchronous, active-high
- `iValid`  in  1  pixel strobe; one pixel per asserted cycle
- `iSof`  in  1  start of frame; qualifies the pixel at (0,0); ignored unless `iValid`
- `iPixel`  in  DATA_W  pixel value
- `oValid`  out  1  window strobe
- `oNum1`..`oNum9`  out  DATA_W each  window taps, row-major; `oNum1` = top-left, `oNum9` = newest pixel
- `oX`  out  X_W  column of newest pixel (bottom-right tap)
- `oY`  out  Y_W  row of newest pixel
- `oEof`  out  1  asserted with the window produced by the last pixel of a frame

## Operation
- Reset: state IDLE; x, y counters = 0; all outputs = 0. Line-buffer RAM contents are don't-care.
- States:
  - IDLE: pixels are dropped unless `iValid && iSof`. That pixel is accepted as (0,0) and the state moves to RUN.
  - RUN: each `iValid` pixel is accepted at the current (x,y).
- Counter update:
  - x increments per accepted pixel.
  - At x = IMG_W-1, x wraps to 0 and y increments.
  - At (IMG_W-1, IMG_H-1) the pixel is accepted and the state returns to IDLE.
- `iValid && iSof` in RUN restarts the frame. That pixel is taken as (0,0); the partial frame is abandoned without `oEof`.
- Line buffers:
  - line1 holds row y-1 and line2 holds row y-2, each IMG_W deep, indexed by x.
  - On accept: line2[x] <= line1[x]; line1[x] <= iPixel. Both are read-before-write at the same x.
- Tap array: three columns of three taps (top = line2, mid = line1, bottom = iPixel). It shifts left by one column per accepted pixel.
- Tap mapping: `oNum1..3` = P(y-2, x-2..x); `oNum4..6` = P(y-1, x-2..x); `oNum7..9` = P(y, x-2..x).
- Columns never wrap across lines. Taps from x-1 or x-2 < 0, or from rows < 0, are out-of-image; handling is set by Configuration.
- No backpressure; the consumer always accepts.

## Timing
- Throughput: one pixel per cycle; gaps in `iValid` are allowed anywhere, including mid-line.
- Latency: outputs are registered. `oValid`, taps, `oX`/`oY` and `oEof` update on the edge after the accepting cycle.
- `oValid` is a one-cycle pulse per emitted window. Taps, `oX`, `oY` hold their last values while `oValid` = 0. `oEof` is only ever high together with `oValid`.
- Reset mid-frame takes priority over all inputs. The next cycle shows outputs = 0 and state IDLE, and the next frame requires `iSof`.
- Stale line-buffer data from a previous or aborted frame never reaches a valid output. It is either masked to zero or not emitted.

## Configuration
- `WINDOW_ZERO_PAD_EN` defined:
  - A window is emitted for every accepted pixel (IMG_W*IMG_H per frame).
  - Out-of-image taps are forced to 0.
  - `oEof` rides with the window of pixel (IMG_W-1, IMG_H-1).
- `WINDOW_ZERO_PAD_EN` undefined:
  - Windows are emitted only when x >= 2 and y >= 2, giving (IMG_W-2)*(IMG_H-2) per frame.
  - No masking logic is present.
  - `oEof` behaves as above; the last pixel is always interior.

## Test plan
All cases use IMG_W = 4, IMG_H = 3, pixel value = 10y + x + 1.
- Reset: hold `iRst` 2 cycles -> all outputs 0. Pixels with `iValid` = 1, `iSof` = 0 in IDLE -> no `oValid`.
- No pad, continuous frame -> exactly 2 windows:
  - First window (oX=2, oY=2): taps 1,2,3,11,12,13,21,22,23, one cycle after pixel (2,2).
  - Second window: taps 2,3,4,12,13,14,22,23,24 with `oEof` = 1.
- Zero pad, continuous frame -> 12 windows.
  - Window at (0,0): `oNum9` = 1, all other taps 0.
  - Window at (1,1): `oNum5` = 1, `oNum6` = 2, `oNum8` = 11, `oNum9` = 12, others 0.
- Same frame with random 0-3 cycle `iValid` gaps -> identical window sequence; `oValid` pulses once per emitted window.
- `iSof` reasserted at pixel (1,1) of frame A with frame B data (+100):
  - No `oEof` for A.
  - B's windows contain no A values in unmasked positions (zero pad) or only B values (no pad).
- `iRst` asserted at pixel (2,1) -> outputs 0 next cycle. Pixels are ignored until `iSof`, and the following full frame produces the correct windows.
